// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO unit: ALU op codes, divider FSM encoding
// and the magnitude helper used by the signed-divide front end.
package hilo_pkg;

  localparam logic [5:0] ALUOP_MTHI  = 6'b100000;
  localparam logic [5:0] ALUOP_MTLO  = 6'b100001;
  localparam logic [5:0] ALUOP_MFHI  = 6'b100010;
  localparam logic [5:0] ALUOP_MFLO  = 6'b100011;
  localparam logic [5:0] ALUOP_MULT  = 6'b011011;
  localparam logic [5:0] ALUOP_MULTU = 6'b001011;
  localparam logic [5:0] ALUOP_DIV   = 6'b011100;
  localparam logic [5:0] ALUOP_DIVU  = 6'b001100;

  localparam int unsigned DIV_STEPS = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_radix2.sv
// Iterative unsigned 32/32 restoring divider: one quotient bit per cycle,
// 32 cycles after start, done pulses for one cycle; abort drops any work.
module div_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done,
  output logic [4:0]  count
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic        running_q;
  logic        done_q;
  logic [4:0]  count_q;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        fits;

  // Shift the next dividend bit into the partial remainder and try to subtract.
  assign trial = {rem_q, quo_q[31]};
  assign diff  = trial - {1'b0, dvs_q};
  assign fits  = ~diff[32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      dvs_q     <= 32'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= 5'd0;
    end else if (abort) begin
      running_q <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= 5'd0;
    end else if (start) begin
      quo_q     <= dividend;
      rem_q     <= 32'd0;
      dvs_q     <= divisor;
      running_q <= 1'b1;
      done_q    <= 1'b0;
      count_q   <= 5'd0;
    end else if (running_q) begin
      quo_q   <= {quo_q[30:0], fits};
      rem_q   <= fits ? diff[31:0] : trial[31:0];
      count_q <= count_q + 5'd1;
      if (count_q == 5'd31) begin
        running_q <= 1'b0;
        done_q    <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: mthi/mtlo/mfhi/mflo, single-cycle mult/multu and,
// when HILO_DIV_EN is defined, a 33-cycle stalling div/divu.
module hilo_unit
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  aluopE,
  input  logic        validE,
  input  logic        flushE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  output logic [31:0] hilo_rdata,
  output logic        div_stall,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output div_state_e  div_state
);

  // Handshake: an E-stage op is taken when validE && !flushE. While div_stall is
  // high the pipeline holds E unchanged; the op retires on the first edge with it low.
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        op_live;
  logic        single_ok;
  logic        div_wr;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] div_result;

  assign op_live = validE && !flushE;
  // Sign-extended 64x64 product truncated to 64 bits gives the signed result.
  assign prod_s  = {{32{srcaE[31]}}, srcaE} * {{32{srcbE[31]}}, srcbE};
  assign prod_u  = {32'd0, srcaE} * {32'd0, srcbE};

  always_comb begin
    hilo_rdata = 32'd0;
    case (aluopE)
      ALUOP_MFHI: hilo_rdata = hi_q;
      ALUOP_MFLO: hilo_rdata = lo_q;
      default:    hilo_rdata = 32'd0;
    endcase
  end

`ifdef HILO_DIV_EN
  div_state_e  state_q;
  div_state_e  state_d;
  logic        div_start;
  logic        div_done;
  logic [4:0]  div_count;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        is_div;
  logic        div_signed;
  logic        neg_quot_q;
  logic        neg_rem_q;

  assign is_div     = (aluopE == ALUOP_DIV) || (aluopE == ALUOP_DIVU);
  assign div_signed = (aluopE == ALUOP_DIV);
  assign mag_a      = abs32(srcaE, div_signed);
  assign mag_b      = abs32(srcbE, div_signed);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_IDLE;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (div_start) begin
        neg_quot_q <= div_signed && (srcaE[31] ^ srcbE[31]);
        neg_rem_q  <= div_signed && srcaE[31];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    div_stall = 1'b0;
    div_wr    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (op_live && is_div && (srcbE != 32'd0)) begin
          div_start = 1'b1;
          div_stall = 1'b1;
          state_d   = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        div_stall = 1'b1;
        if (div_count == 5'(DIV_STEPS - 1)) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        div_wr  = div_done;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    // A flush cancels the E-stage op outright, whatever the divider is doing.
    if (flushE) begin
      state_d   = DIV_IDLE;
      div_start = 1'b0;
      div_stall = 1'b0;
      div_wr    = 1'b0;
    end
  end

  div_radix2 u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flushE),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quot),
    .remainder (div_rem),
    .done      (div_done),
    .count     (div_count)
  );

  assign div_result = {neg_rem_q ? (~div_rem + 32'd1) : div_rem,
                       neg_quot_q ? (~div_quot + 32'd1) : div_quot};
  assign single_ok  = (state_q == DIV_IDLE);
  assign div_state  = state_q;
`else
  assign div_stall  = 1'b0;
  assign div_wr     = 1'b0;
  assign div_result = 64'd0;
  assign single_ok  = 1'b1;
  assign div_state  = DIV_IDLE;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (div_wr) begin
      {hi_q, lo_q} <= div_result;
    end else if (op_live && single_ok) begin
      case (aluopE)
        ALUOP_MTHI:  hi_q <= srcaE;
        ALUOP_MTLO:  lo_q <= srcaE;
        ALUOP_MULT:  {hi_q, lo_q} <= prod_s;
        ALUOP_MULTU: {hi_q, lo_q} <= prod_u;
        default: ;
      endcase
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule
